// File: rtl/usb_pkg.sv
// Shared USB constants: PIDs, bit timing default, CRC5 parameters and the token TX state type.
package usb_pkg;

  localparam int unsigned ClksPerBitDef = 4;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;

  localparam logic [7:0] SyncByte = 8'h80;

  localparam logic [4:0] Crc5Poly = 5'b00101;
  localparam logic [4:0] Crc5Seed = 5'b11111;

  // Consecutive raw ones that force a stuffed zero.
  localparam int unsigned StuffRun = 6;

  typedef enum logic [1:0] {
    StIdle,
    StSyncPid,
    StToken,
    StEop
  } tok_state_e;

  // One step of the serial CRC5 LFSR; data enters LSB-first.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    return {crc[3:0], 1'b0} ^ ((crc[4] ^ din) ? Crc5Poly : 5'b00000);
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI line encoder with bit stuffing. Owns the J/K line state and the run-of-ones counter;
// stall_o tells the shifter that the next strobe will be spent on a stuffed zero.
module usb_nrzi_stuffer
  import usb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic bit_valid_i,
  input  logic bit_i,
  output logic stall_o,
  output logic line_o
);

  logic       line_q, line_d;
  logic [2:0] ones_q, ones_d;

  assign stall_o = (ones_q == 3'(StuffRun));
  assign line_o  = line_q;

  always_comb begin
    line_d = line_q;
    ones_d = ones_q;
    if (clr_i) begin
      line_d = 1'b1;
      ones_d = '0;
    end else if (bit_valid_i) begin
      if (stall_o || !bit_i) begin
        // A stuffed zero and a real zero both toggle the line and end the run.
        line_d = ~line_q;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= 1'b1;
      ones_q <= '0;
    end else begin
      line_q <= line_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_token_tx.sv
// Full-speed USB token packet transmitter: SYNC, PID, addr, endp, CRC5, NRZI with bit stuffing,
// then EOP. The first line state is driven in the cycle right after an accepted start.
module usb_token_tx
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDef
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] token_pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  output logic       busy,
  output logic       done,
  output logic       tx_en,
  output logic       tx_j,
  output logic       tx_se0
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LastBit  = 4'd15;
  localparam logic [3:0] CrcFirst = 4'd11;

  tok_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        bit_q, bit_d;
  logic [14:0]       sh_q, sh_d;
  logic [4:0]        crc_q, crc_d;
  logic [6:0]        addr_q, addr_d;
  logic [3:0]        endp_q, endp_d;
  logic              tx_en_q, tx_en_d;
  logic              tx_se0_q, tx_se0_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       tick;
  logic [3:0] nxt_bit;
  logic       bit_stb;
  logic       bit_raw;
  logic       stuff_clr;
  logic       stall;
  logic       line;

  assign tick    = (timer_q == TimerLast);
  assign nxt_bit = bit_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    tx_en_d   = tx_en_q;
    tx_se0_d  = tx_se0_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_stb   = 1'b0;
    bit_raw   = 1'b0;
    stuff_clr = 1'b0;

    if (state_q != StIdle) begin
      timer_d = tick ? '0 : timer_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSyncPid;
          busy_d  = 1'b1;
          tx_en_d = 1'b1;
          timer_d = '0;
          bit_d   = '0;
          crc_d   = Crc5Seed;
          addr_d  = addr;
          endp_d  = endp;
          // Bit 0 goes straight to the encoder; the remaining 15 wait in the shifter.
          {sh_d, bit_raw} = {~token_pid, token_pid, SyncByte};
          bit_stb = 1'b1;
        end
      end

      StSyncPid: begin
        if (tick) begin
          bit_stb = 1'b1;
          if (stall) begin
            bit_raw = 1'b0;
          end else if (bit_q == LastBit) begin
            state_d = StToken;
            bit_d   = '0;
            sh_d    = {5'b00000, endp_q, addr_q[6:1]};
            bit_raw = addr_q[0];
            crc_d   = crc5_step(crc_q, addr_q[0]);
          end else begin
            bit_d   = nxt_bit;
            bit_raw = sh_q[0];
            sh_d    = sh_q >> 1;
          end
        end
      end

      StToken: begin
        if (tick) begin
          if (stall) begin
            bit_stb = 1'b1;
          end else if (bit_q == LastBit) begin
            state_d   = StEop;
            bit_d     = '0;
            stuff_clr = 1'b1;
            tx_se0_d  = 1'b1;
          end else begin
            bit_stb = 1'b1;
            bit_d   = nxt_bit;
            if (nxt_bit < CrcFirst) begin
              bit_raw = sh_q[0];
              sh_d    = sh_q >> 1;
              crc_d   = crc5_step(crc_q, sh_q[0]);
            end else begin
              // CRC goes out inverted, MSB first; shifting left exposes the next bit.
              bit_raw = ~crc_q[4];
              crc_d   = {crc_q[3:0], 1'b0};
            end
          end
        end
      end

      StEop: begin
        if (tick) begin
          if (bit_q == 4'd2) begin
            state_d = StIdle;
            bit_d   = '0;
            tx_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d    = nxt_bit;
            tx_se0_d = (bit_q == 4'd0);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      crc_q    <= Crc5Seed;
      addr_q   <= '0;
      endp_q   <= '0;
      tx_en_q  <= 1'b0;
      tx_se0_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      crc_q    <= crc_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      tx_en_q  <= tx_en_d;
      tx_se0_q <= tx_se0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  usb_nrzi_stuffer u_stuffer (
    .clk_i      (clk_48),
    .rst_ni     (rst_n),
    .clr_i      (stuff_clr),
    .bit_valid_i(bit_stb),
    .bit_i      (bit_raw),
    .stall_o    (stall),
    .line_o     (line)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign tx_en  = tx_en_q;
  assign tx_se0 = tx_se0_q;
  assign tx_j   = line;

endmodule

// File: tb/tb_usb_token_tx.sv
// Self-checking bench for usb_token_tx: known-token vectors, restart/reset corner cases and
// random tokens against a line-state model built from packet-format rules.
module tb_usb_token_tx;

  localparam int unsigned Cpb = 4;
  localparam logic [3:0] POut   = 4'b0001;
  localparam logic [3:0] PIn    = 4'b1001;
  localparam logic [3:0] PSetup = 4'b1101;

  logic       clk_48 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] token_pid = '0;
  logic [6:0] addr = '0;
  logic [3:0] endp = '0;
  logic       busy, done, tx_en, tx_j, tx_se0;

  usb_token_tx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk_48   (clk_48),
    .rst_n    (rst_n),
    .start    (start),
    .token_pid(token_pid),
    .addr     (addr),
    .endp     (endp),
    .busy     (busy),
    .done     (done),
    .tx_en    (tx_en),
    .tx_j     (tx_j),
    .tx_se0   (tx_se0)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  a;
    logic [3:0]  e;
    logic [23:0] bytes;   // {byte3, byte2, pid byte} as decoded from the line
    int          stuffs;
  } vec_t;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];   // expected line state per bit time: 0=K, 1=J, 2=SE0
  logic [1:0] obs_q[$];
  int         en_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] line_code();
    return tx_se0 ? 2'b10 : {1'b0, tx_j};
  endfunction

  // CRC5 by polynomial long division; the all-ones preset is folded into the dividend.
  function automatic logic [4:0] crc5_ref(input logic [10:0] msg);
    logic [15:0] v;
    v = 16'hF800;
    for (int i = 0; i < 11; i++) v[15-i] = v[15-i] ^ msg[i];
    for (int p = 15; p >= 5; p--) if (v[p]) v[p -: 6] = v[p -: 6] ^ 6'b100101;
    return ~v[4:0];
  endfunction

  function automatic logic [31:0] raw_bits(input logic [3:0] pid, input logic [6:0] a,
                                           input logic [3:0] e);
    logic [31:0] r;
    logic [4:0]  c;
    c        = crc5_ref({e, a});
    r[7:0]   = 8'h80;
    r[15:8]  = {~pid, pid};
    r[22:16] = a;
    r[26:23] = e;
    for (int j = 0; j < 5; j++) r[27+j] = c[4-j];
    return r;
  endfunction

  task automatic build_expected(input logic [31:0] raw);
    int         ones;
    logic [1:0] ln;
    ones = 0;
    ln   = 2'b01;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (raw[i]) ones++;
      else begin
        ln   = ln ^ 2'b01;
        ones = 0;
      end
      exp_q.push_back(ln);
      if (ones == 6) begin
        ln   = ln ^ 2'b01;
        ones = 0;
        exp_q.push_back(ln);
      end
    end
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
  endtask

  // NRZI-decode and destuff the observed data bit times (EOP excluded).
  function automatic logic [31:0] decode_obs();
    logic [31:0] r;
    logic [1:0]  prev;
    int          ones;
    int          n;
    r    = '0;
    prev = 2'b01;
    ones = 0;
    n    = 0;
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      logic b;
      b    = (obs_q[i] == prev);
      prev = obs_q[i];
      if (ones == 6) begin
        ones = 0;
        continue;
      end
      ones = b ? ones + 1 : 0;
      if (n < 32) r[n] = b;
      n++;
    end
    return r;
  endfunction

  // Starts a packet now (at posedge+1) and checks every cycle against the model.
  task automatic run_packet(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                            input int restart_at, input int abort_at, input string tag,
                            output bit aborted);
    int k;
    int bad;
    build_expected(raw_bits(pid, a, e));
    obs_q.delete();
    en_cnt    = 0;
    aborted   = 1'b0;
    token_pid = pid;
    addr      = a;
    endp      = e;
    start     = 1'b1;
    @(posedge clk_48);
    #1;
    start     = 1'b0;
    token_pid = ~pid;
    addr      = ~a;
    endp      = ~e;
    k = 1;
    for (int i = 0; i < exp_q.size() && !aborted; i++) begin
      bad = 0;
      for (int c = 0; c < Cpb; c++) begin
        if (k == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk({tag, " reset-abort outputs"}, {27'd0, tx_en, busy, done, tx_se0, tx_j}, 32'h1);
          aborted = 1'b1;
          break;
        end
        start = (k == restart_at);
        if (start) begin
          token_pid = PIn;
          addr      = 7'h55;
          endp      = 4'hA;
        end
        if (line_code() != exp_q[i] || tx_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
        en_cnt += int'(tx_en);
        if (c == 1) obs_q.push_back(line_code());
        @(posedge clk_48);
        #1;
        k++;
      end
      if (!aborted) chk($sformatf("%s bit%0d bad cycles", tag, i), bad, 0);
    end
    start = 1'b0;
    if (!aborted) chk({tag, " done/idle"}, {27'd0, done, tx_en, busy, tx_se0, tx_j}, 32'b10001);
  endtask

  initial begin
    vec_t        tbl[3];
    logic [3:0]  pids[3];
    logic [31:0] r;
    bit          ab;
    int          dn;
    int          en;
    int          gap;
    logic [3:0]  p;
    logic [6:0]  a;
    logic [3:0]  e;

    tbl[0] = '{PSetup, 7'h00, 4'h0, 24'h10_00_2D, 0};
    tbl[1] = '{PIn,    7'h00, 4'h0, 24'h10_00_69, 0};
    tbl[2] = '{POut,   7'h7F, 4'hF, 24'h47_FF_E1, 2};
    pids   = '{POut, PIn, PSetup};

    repeat (3) @(posedge clk_48);
    #1;
    chk("reset outputs", {27'd0, tx_en, busy, done, tx_se0, tx_j}, 32'h1);

    // First start coincides with reset release; the table runs back to back.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_packet(tbl[i].pid, tbl[i].a, tbl[i].e, 0, 0, $sformatf("vec%0d", i), ab);
      r = decode_obs();
      chk($sformatf("vec%0d sync", i), {24'd0, r[7:0]}, 32'h80);
      chk($sformatf("vec%0d bytes", i), {8'd0, r[31:8]}, {8'd0, tbl[i].bytes});
      chk($sformatf("vec%0d stuff count", i), obs_q.size() - 35, tbl[i].stuffs);
      chk($sformatf("vec%0d tx_en cycles", i), en_cnt, (35 + tbl[i].stuffs) * Cpb);
    end

    // A second start mid-packet must be dropped entirely.
    repeat (2) @(posedge clk_48);
    #1;
    run_packet(PSetup, 7'h12, 4'h3, 50, 0, "restart", ab);
    chk("restart decode", decode_obs(), raw_bits(PSetup, 7'h12, 4'h3));
    dn = 0;
    en = 0;
    repeat (40) begin
      @(posedge clk_48);
      #1;
      dn += int'(done);
      en += int'(tx_en);
    end
    chk("restart extra done", dn, 0);
    chk("restart extra tx_en", en, 0);

    // Reset mid-packet, then a packet in the first cycle after release.
    run_packet(POut, 7'h2A, 4'h5, 0, 60, "abort", ab);
    repeat (2) @(posedge clk_48);
    #1;
    chk("held in reset", {27'd0, tx_en, busy, done, tx_se0, tx_j}, 32'h1);
    rst_n = 1'b1;
    run_packet(PIn, 7'h33, 4'h9, 0, 0, "post-reset", ab);
    chk("post-reset decode", decode_obs(), raw_bits(PIn, 7'h33, 4'h9));

    for (int n = 0; n < 20; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk_48);
      #1;
      p = pids[$urandom_range(0, 2)];
      a = 7'($urandom);
      e = 4'($urandom);
      run_packet(p, a, e, 0, 0, $sformatf("rnd%0d", n), ab);
      chk($sformatf("rnd%0d decode", n), decode_obs(), raw_bits(p, a, e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
